// File: rtl/seg7_scan_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_mux_if
// Description : Value/control inputs and pin-level outputs of the 7-seg scanner.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] num;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    lz_en;
    logic [NUM_DIGITS-1:0]   blink;
    logic [6:0]              DISPLAY;
    logic                    DP;
    logic [NUM_DIGITS-1:0]   DIGIT;
    logic                    frame_start;

    modport master (
        output num, dp, blank, lz_en, blink,
        input  DISPLAY, DP, DIGIT, frame_start
    );

    modport slave (
        input  num, dp, blank, lz_en, blink,
        output DISPLAY, DP, DIGIT, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_mux
// Description : N-digit common-anode 7-seg scanner with hex decode, DP, blanking,
//               leading-zero suppression and frame-synchronous capture.
//               Optional blinking enabled by defining SEG_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 32768,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_scan_mux_if.slave       bus
);
    localparam int c_CW = $clog2(SCAN_DIV);
    localparam int c_IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(NUM_DIGITS - 1);

    function automatic logic [6:0] f_decode(input logic [3:0] v);
        case (v)
            4'h0: f_decode = 7'b1000000;
            4'h1: f_decode = 7'b1111001;
            4'h2: f_decode = 7'b0100100;
            4'h3: f_decode = 7'b0110000;
            4'h4: f_decode = 7'b0011001;
            4'h5: f_decode = 7'b0010010;
            4'h6: f_decode = 7'b0000010;
            4'h7: f_decode = 7'b1111000;
            4'h8: f_decode = 7'b0000000;
            4'h9: f_decode = 7'b0010000;
            4'hA: f_decode = 7'b0001000;
            4'hB: f_decode = 7'b0000011;
            4'hC: f_decode = 7'b1000110;
            4'hD: f_decode = 7'b0100001;
            4'hE: f_decode = 7'b0000110;
            default: f_decode = 7'b0001110;
        endcase
    endfunction

    logic [c_CW-1:0]         cnt_q, cnt_d;
    logic                    run_q, run_d;
    logic [c_IW-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] num_sh_q, num_sh_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [NUM_DIGITS-1:0]   blank_sh_q, blank_sh_d;
    logic [NUM_DIGITS-1:0]   blink_sh_q, blink_sh_d;
    logic                    lz_sh_q, lz_sh_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dpo_q, dpo_d;
    logic [NUM_DIGITS-1:0]   digit_q, digit_d;
    logic                    frame_start_q, frame_start_d;
    logic                    w_tick, w_frame_tick, w_phase_on;

    assign w_tick = (cnt_q == c_CW'(SCAN_DIV - 1));

    always_comb begin
        cnt_d = w_tick ? '0 : cnt_q + 1'b1;
        run_d = run_q;
        idx_d = idx_q;
        if (w_tick) begin
            run_d = 1'b1;
            idx_d = (!run_q || idx_q == c_LAST) ? '0 : idx_q + 1'b1;
        end
        w_frame_tick = w_tick && (idx_d == '0);
    end

    // The _d shadows already hold the freshly captured frame on a frame tick,
    // so digit 0 of the new frame is rendered from the values sampled there.
    always_comb begin
        num_sh_d   = w_frame_tick ? bus.num   : num_sh_q;
        dp_sh_d    = w_frame_tick ? bus.dp    : dp_sh_q;
        blank_sh_d = w_frame_tick ? bus.blank : blank_sh_q;
        blink_sh_d = w_frame_tick ? bus.blink : blink_sh_q;
        lz_sh_d    = w_frame_tick ? bus.lz_en : lz_sh_q;
    end

`ifdef SEG_BLINK_EN
    localparam int c_FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [c_FW-1:0] fcnt_q, fcnt_d;
    logic            phase_q, phase_d;
    logic            ph_sh_q, ph_sh_d;

    // Each frame latches the phase in force when it starts, so a frame never
    // changes blink state partway through.
    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        ph_sh_d = ph_sh_q;
        if (w_frame_tick) begin
            ph_sh_d = phase_q;
            if (fcnt_q == c_FW'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q  <= '0;
            phase_q <= 1'b1;
            ph_sh_q <= 1'b1;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            ph_sh_q <= ph_sh_d;
        end
    end

    assign w_phase_on = ph_sh_d;
`else
    assign w_phase_on = (BLINK_FRAMES > 0);
`endif

    always_comb begin
        logic [NUM_DIGITS:0] zero_from;
        logic [3:0]          nib;
        logic                dp_k, blank_k, blink_k, zf_k, lz_sup, off;
        zero_from             = '0;
        zero_from[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--)
            zero_from[i] = zero_from[i+1] & (num_sh_d[4*i +: 4] == 4'h0);
        nib = '0; dp_k = 1'b0; blank_k = 1'b0; blink_k = 1'b0; zf_k = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (c_IW'(i) == idx_d) begin
                nib     = num_sh_d[4*i +: 4];
                dp_k    = dp_sh_d[i];
                blank_k = blank_sh_d[i];
                blink_k = blink_sh_d[i];
                zf_k    = zero_from[i];
            end
        end
        lz_sup = lz_sh_d && (idx_d != '0) && zf_k;
        // A suppressed digit keeps its anode only to show a requested DP.
        off = blank_k | (blink_k & ~w_phase_on) | (lz_sup & ~dp_k);

        seg_d         = seg_q;
        dpo_d         = dpo_q;
        digit_d       = digit_q;
        frame_start_d = w_frame_tick;
        if (w_tick) begin
            seg_d   = lz_sup ? 7'h7F : f_decode(nib);
            dpo_d   = off ? 1'b1 : ~dp_k;
            digit_d = '1;
            for (int i = 0; i < NUM_DIGITS; i++)
                if (!off && c_IW'(i) == idx_d) digit_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            run_q         <= 1'b0;
            idx_q         <= '0;
            num_sh_q      <= '0;
            dp_sh_q       <= '0;
            blank_sh_q    <= '0;
            blink_sh_q    <= '0;
            lz_sh_q       <= 1'b0;
            seg_q         <= 7'h7F;
            dpo_q         <= 1'b1;
            digit_q       <= '1;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            run_q         <= run_d;
            idx_q         <= idx_d;
            num_sh_q      <= num_sh_d;
            dp_sh_q       <= dp_sh_d;
            blank_sh_q    <= blank_sh_d;
            blink_sh_q    <= blink_sh_d;
            lz_sh_q       <= lz_sh_d;
            seg_q         <= seg_d;
            dpo_q         <= dpo_d;
            digit_q       <= digit_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.DISPLAY     = seg_q;
    assign bus.DP          = dpo_q;
    assign bus.DIGIT       = digit_q;
    assign bus.frame_start = frame_start_q;

endmodule
`default_nettype wire
